// File: rtl/lcd_hex_writer.sv
// lcd_hex_writer: HD44780 16x2 controller that prints two 32-bit words as
// eight uppercase hex digits each (line1 on row 1, line2 on row 2).
// Every byte goes through SETUP -> PULSE -> HOLD -> WAIT, and the delays
// scale with CLK_FREQ_MHZ.
// Optional feature macro: LCD_REFRESH_ON_CHANGE_EN. When it is defined, the
// controller parks in IDLE after each frame and redraws only when the inputs
// differ from the last snapshot.
module lcd_hex_writer #(
    parameter int CLK_FREQ_MHZ = 50,
    parameter int POWERUP_US   = 15000,
    parameter int CMD_US       = 40,
    parameter int CLEAR_US     = 1640,
    parameter int EN_PULSE     = 12
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] line1,
    input  logic [31:0] line2,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic        LCD_EN,
    output logic        init_done,
    output logic        frame_done
);

    localparam logic [31:0] PWR_CYC   = 32'(POWERUP_US * CLK_FREQ_MHZ);
    localparam logic [31:0] CMD_CYC   = 32'(CMD_US * CLK_FREQ_MHZ);
    localparam logic [31:0] CLEAR_CYC = 32'(CLEAR_US * CLK_FREQ_MHZ);
    localparam logic [31:0] PULSE_CYC = 32'(EN_PULSE);

    // Top-level sequence states
    localparam logic [2:0] ST_PWR   = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_HOME1 = 3'd2;
    localparam logic [2:0] ST_ROW1  = 3'd3;
    localparam logic [2:0] ST_HOME2 = 3'd4;
    localparam logic [2:0] ST_ROW2  = 3'd5;
`ifdef LCD_REFRESH_ON_CHANGE_EN
    localparam logic [2:0] ST_IDLE  = 3'd6;
`endif

    // Per-byte strobe phases
    localparam logic [1:0] PH_SETUP = 2'd0;
    localparam logic [1:0] PH_PULSE = 2'd1;
    localparam logic [1:0] PH_HOLD  = 2'd2;
    localparam logic [1:0] PH_WAIT  = 2'd3;

    logic [2:0]  state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] snap1_q, snap1_d;
    logic [31:0] snap2_q, snap2_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        en_q, en_d;
    logic        init_done_q, init_done_d;
    logic        frame_done_q, frame_done_d;

    // Scratch signals for starting the next byte
    logic        start;
    logic        take_snap;
    logic [2:0]  nstate;
    logic [2:0]  nidx;
    logic [31:0] wait_cyc;

    // Returns {RS, DATA} for byte idx of state st. Row characters come from
    // the snapshot, with the most significant nibble in column 0.
    function automatic logic [8:0] byte_for(input logic [2:0]  st,
                                            input logic [2:0]  idx,
                                            input logic [31:0] s1,
                                            input logic [31:0] s2);
        logic [31:0] word;
        logic [3:0]  nib;
        word = (st == ST_ROW1) ? s1 : s2;
        nib  = 4'(word >> {27'd0, 3'd7 - idx, 2'b00});
        case (st)
            ST_INIT: begin
                case (idx)
                    3'd0:    byte_for = {1'b0, 8'h38};
                    3'd1:    byte_for = {1'b0, 8'h0C};
                    3'd2:    byte_for = {1'b0, 8'h06};
                    default: byte_for = {1'b0, 8'h01};
                endcase
            end
            ST_HOME1: byte_for = {1'b0, 8'h80};
            ST_HOME2: byte_for = {1'b0, 8'hC0};
            ST_ROW1, ST_ROW2:
                byte_for = {1'b1, (nib < 4'd10) ? 8'h30 + {4'h0, nib}
                                                : 8'h37 + {4'h0, nib}};
            default: byte_for = 9'h000;
        endcase
    endfunction

    // Next-state logic for the sequencer, the strobe phases and the outputs
    always_comb begin
        // NOTE: every signal gets a default here so no path can infer a latch.
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap1_d      = snap1_q;
        snap2_d      = snap2_q;
        data_d       = data_q;
        rs_d         = rs_q;
        en_d         = en_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        start        = 1'b0;
        take_snap    = 1'b0;
        nstate       = state_q;
        nidx         = 3'd0;
        // The clear command (last INIT byte) needs the long execution wait
        wait_cyc     = (state_q == ST_INIT && idx_q == 3'd3) ? CLEAR_CYC : CMD_CYC;

        case (state_q)
            ST_PWR: begin
                if (cnt_q == PWR_CYC - 32'd1) begin
                    start  = 1'b1;
                    nstate = ST_INIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
`ifdef LCD_REFRESH_ON_CHANGE_EN
            ST_IDLE: begin
                if ({line1, line2} != {snap1_q, snap2_q}) begin
                    start     = 1'b1;
                    take_snap = 1'b1;
                    nstate    = ST_HOME1;
                end
            end
`endif
            default: begin
                case (phase_q)
                    PH_SETUP: begin
                        if (cnt_q == 32'd1) begin
                            phase_d = PH_PULSE;
                            en_d    = 1'b1;
                            cnt_d   = 32'd0;
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                    PH_PULSE: begin
                        if (cnt_q == PULSE_CYC - 32'd1) begin
                            phase_d = PH_HOLD;
                            en_d    = 1'b0;
                            cnt_d   = 32'd0;
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                    PH_HOLD: begin
                        if (cnt_q == 32'd1) begin
                            phase_d = PH_WAIT;
                            cnt_d   = 32'd0;
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                    default: begin
                        if (cnt_q == wait_cyc - 32'd1) begin
                            case (state_q)
                                ST_INIT: begin
                                    start = 1'b1;
                                    if (idx_q == 3'd3) begin
                                        nstate      = ST_HOME1;
                                        take_snap   = 1'b1;
                                        init_done_d = 1'b1;
                                    end else begin
                                        nidx = idx_q + 3'd1;
                                    end
                                end
                                ST_HOME1: begin
                                    start  = 1'b1;
                                    nstate = ST_ROW1;
                                end
                                ST_ROW1: begin
                                    start = 1'b1;
                                    if (idx_q == 3'd7) nstate = ST_HOME2;
                                    else               nidx   = idx_q + 3'd1;
                                end
                                ST_HOME2: begin
                                    start  = 1'b1;
                                    nstate = ST_ROW2;
                                end
                                default: begin
                                    if (idx_q != 3'd7) begin
                                        start = 1'b1;
                                        nidx  = idx_q + 3'd1;
                                    end else begin
                                        frame_done_d = 1'b1;
`ifdef LCD_REFRESH_ON_CHANGE_EN
                                        state_d = ST_IDLE;
                                        cnt_d   = 32'd0;
`else
                                        start     = 1'b1;
                                        take_snap = 1'b1;
                                        nstate    = ST_HOME1;
`endif
                                    end
                                end
                            endcase
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                endcase
            end
        endcase

        if (take_snap) begin
            snap1_d = line1;
            snap2_d = line2;
        end
        // LCD_DATA/RS are loaded only when a byte begins
        if (start) begin
            state_d        = nstate;
            idx_d          = nidx;
            phase_d        = PH_SETUP;
            cnt_d          = 32'd0;
            {rs_d, data_d} = byte_for(nstate, nidx, snap1_d, snap2_d);
        end
    end

    // State registers; an asynchronous reset drops LCD_EN immediately
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_PWR;
            phase_q      <= PH_SETUP;
            cnt_q        <= 32'd0;
            idx_q        <= 3'd0;
            snap1_q      <= 32'd0;
            snap2_q      <= 32'd0;
            data_q       <= 8'h00;
            rs_q         <= 1'b0;
            en_q         <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all flops update together from pre-edge values.
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap1_q      <= snap1_d;
            snap2_q      <= snap2_d;
            data_q       <= data_d;
            rs_q         <= rs_d;
            en_q         <= en_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign LCD_DATA   = data_q;
    assign LCD_RS     = rs_q;
    assign LCD_RW     = 1'b0;
    assign LCD_EN     = en_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Testbench for lcd_hex_writer. Stimulus pushes the expected LCD byte stream
// into a queue, and a monitor pops an entry at every EN falling edge.
// The monitor also checks strobe width, data stability and the gaps between
// strobes. Delays are scaled with CLK_FREQ_MHZ=1.
module tb_lcd_hex_writer;

    localparam int POWERUP_US = 15000;
    localparam int CMD_US     = 40;
    localparam int CLEAR_US   = 1640;
    localparam int EN_PULSE   = 12;
    localparam int BYTE_CYC   = 4 + EN_PULSE + CMD_US;
    localparam int FRAME_CYC  = 18 * BYTE_CYC;
    localparam int INIT_END   = POWERUP_US + 3 * BYTE_CYC + 4 + EN_PULSE + CLEAR_US;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_byte_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] line1, line2;
    logic [7:0]  LCD_DATA;
    logic        LCD_RS, LCD_RW, LCD_EN, init_done, frame_done;

    lcd_byte_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int t = 0;

    // Monitor state
    int        mon_cyc = 0, hi_cnt = 0, stable_cnt = 0, last_fall = 0;
    int        rise_count = 0, fd_count = 0;
    bit        en_prev = 0, fd_prev = 0, have_fall = 0, last_clear = 0, last_rs = 0;
    bit        stab_err = 0, hold_left = 0;
    lcd_byte_t bus, prev_bus, latched, e;

    always #5 clock = ~clock;

    lcd_hex_writer #(
        .CLK_FREQ_MHZ(1),
        .POWERUP_US  (POWERUP_US),
        .CMD_US      (CMD_US),
        .CLEAR_US    (CLEAR_US),
        .EN_PULSE    (EN_PULSE)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .line1     (line1),
        .line2     (line2),
        .LCD_DATA  (LCD_DATA),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_EN    (LCD_EN),
        .init_done (init_done),
        .frame_done(frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", name, act, req, t);
        end
    endtask

    // Reference model: ASCII digit for a nibble
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'(int'(n) + 48);   // '0'..'9'
        return 8'(int'(n) - 10 + 65);             // 'A'..'F'
    endfunction

    task automatic push_init();
        exp_q.push_back('{1'b0, 8'h38});
        exp_q.push_back('{1'b0, 8'h0C});
        exp_q.push_back('{1'b0, 8'h06});
        exp_q.push_back('{1'b0, 8'h01});
    endtask

    task automatic push_frame(input logic [31:0] l1, input logic [31:0] l2);
        exp_q.push_back('{1'b0, 8'h80});
        for (int i = 0; i < 8; i++) exp_q.push_back('{1'b1, hex_char(l1[31 - 4 * i -: 4])});
        exp_q.push_back('{1'b0, 8'hC0});
        for (int i = 0; i < 8; i++) exp_q.push_back('{1'b1, hex_char(l2[31 - 4 * i -: 4])});
    endtask

    task automatic step();
        @(negedge clock);
        t++;
    endtask

    task automatic wait_until(input int target);
        while (t < target) step();
    endtask

    task automatic release_reset();
        @(negedge clock);
        #2 reset_n = 1'b1;
        t = 0;
    endtask

    // Checks the power-up wait, the first strobe and the init_done timing
    task automatic powerup_check();
        bit en_seen = 0;
        do begin
            step();
            if (LCD_EN) en_seen = 1;
        end while (LCD_DATA != 8'h38 && t < POWERUP_US + 5000);
        check("powerup_len", t, POWERUP_US);
        check("en_quiet_powerup", en_seen, 0);
        while (!LCD_EN && t < POWERUP_US + 100) step();
        check("first_en_rise", t, POWERUP_US + 2);
        while (!init_done && t < INIT_END + 1000) step();
        check("init_done_time", t, INIT_END);
        check("home1_after_init", {LCD_RS, LCD_DATA}, 9'h080);
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge
    always @(negedge clock) begin
        if (!reset_n) begin
            mon_cyc    = 0;
            en_prev    = 0;
            fd_prev    = 0;
            have_fall  = 0;
            hold_left  = 0;
            stable_cnt = 0;
        end else begin
            mon_cyc++;
            bus        = {LCD_RS, LCD_DATA};
            stable_cnt = (bus == prev_bus) ? stable_cnt + 1 : 1;
            prev_bus   = bus;
            if (LCD_EN && !en_prev) begin
                rise_count++;
                check("setup_before_en", stable_cnt >= 3, 1);
                if (have_fall) check("strobe_gap", mon_cyc - last_fall, last_clear ? 4 + CLEAR_US : 4 + CMD_US);
                hi_cnt   = 1;
                latched  = bus;
                stab_err = 0;
            end else if (LCD_EN) begin
                hi_cnt++;
                if (bus != latched) stab_err = 1;
            end else if (en_prev) begin
                check("en_width", hi_cnt, EN_PULSE);
                if (bus != latched) stab_err = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got 0x%0h, expected no strobe (t=%0d)", latched, t);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_byte", latched, e);
                end
                hold_left  = 1;
                last_fall  = mon_cyc;
                last_clear = (latched == 9'h001);
                last_rs    = latched.rs;
                have_fall  = 1;
            end else if (hold_left) begin
                if (bus != latched) stab_err = 1;
                hold_left = 0;
                check("data_stable", stab_err, 0);
            end
            if (frame_done) begin
                fd_count++;
                check("fd_one_cycle", fd_prev, 0);
                check("fd_timing", mon_cyc - last_fall, 2 + CMD_US);
                check("fd_after_char", last_rs, 1);
`ifndef LCD_REFRESH_ON_CHANGE_EN
                check("fd_home_cmd", bus, 9'h080);
`endif
            end
            fd_prev = frame_done;
            en_prev = LCD_EN;
        end
    end

    initial begin
        int rises;
        reset_n = 1'b0;
        line1   = 32'h8C0A_FF13;
`ifdef LCD_REFRESH_ON_CHANGE_EN
        line2   = 32'h0000_0011;
`else
        line2   = 32'h0000_001F;
`endif
        repeat (3) @(negedge clock);
        check("rst_data", LCD_DATA, 8'h00);
        check("rst_rs", LCD_RS, 0);
        check("rst_rw", LCD_RW, 0);
        check("rst_en", LCD_EN, 0);
        check("rst_init_done", init_done, 0);
        check("rst_frame_done", frame_done, 0);

        push_init();
        push_frame(line1, line2);
        release_reset();
        powerup_check();

`ifdef LCD_REFRESH_ON_CHANGE_EN
        // After one frame the controller must go quiet while inputs hold
        wait_until(INIT_END + FRAME_CYC + 10);
        check("queue_drained_frame0", exp_q.size(), 0);
        rises = rise_count;
        wait_until(t + 20000);
        check("idle_no_en", rise_count, rises);
        check("idle_one_fd", fd_count, 1);
        line2[0] = ~line2[0];
        push_frame(line1, line2);
        while (exp_q.size() != 0 && t < INIT_END + 2 * FRAME_CYC + 20200) step();
        check("queue_drained_refresh", exp_q.size(), 0);
        check("refresh_fd", fd_count, 2);
        line2[0] = ~line2[0];
        push_frame(line1, line2);
`else
        // Change line1 partway through ROW1; the change must wait one frame
        wait_until(INIT_END + 300);
        line1 = 32'hDEAD_BEEF;
        push_frame(line1, line2);
        for (int k = 1; k <= 4; k++) begin
            wait_until(INIT_END + k * FRAME_CYC + 500);
            if (k == 1) begin
                line1 = 32'h0123_4567;
                line2 = 32'h89AB_CDEF;
            end else begin
                line1 = $urandom;
                line2 = $urandom;
            end
            push_frame(line1, line2);
        end
        wait_until(INIT_END + 5 * FRAME_CYC + 200);
`endif

        // Reset while EN is high
        while (!LCD_EN && t < INIT_END + 7 * FRAME_CYC + 25000) step();
        check("found_en_high", LCD_EN, 1);
        #3 reset_n = 1'b0;
        #1;
        check("async_en_low", LCD_EN, 0);
        check("async_init_done_low", init_done, 0);
        exp_q.delete();
        repeat (3) @(negedge clock);
        line1 = $urandom;
        line2 = $urandom;
        push_init();
        push_frame(line1, line2);
        release_reset();
        powerup_check();
        while (exp_q.size() != 0 && t < INIT_END + FRAME_CYC + 200) step();
        check("queue_drained_final", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
